sme_record_feeder: RTL and testbench
====================================

Name: sme_record_feeder

Overview:
- Upstream stage of the string-matching engine (SME).
- Accepts a byte stream with a valid/ready handshake and assembles complete string or pattern records in a local buffer.
- Replays each record to the SME as one gap-free burst on chardata/isstring/ispattern. A gap would start an SME search prematurely.
- After a pattern burst, holds off further input until the SME reports valid, then returns to accepting input.

Parameters:
- MAX_STR, 32: maximum string record length in bytes; equals SME string storage.
- MAX_PAT, 10: maximum pattern record length in bytes (8 data chars plus '^' and '$').
- WDOG_CYCLES, 255: watchdog limit for the WAIT state; used only with SME_WDOG_EN.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- in_valid  in  1  upstream byte valid
- in_ready  out  1  feeder can accept a byte
- in_data  in  8  upstream byte
- in_is_pattern  in  1  record type; sampled on the first byte of a record only
- in_last  in  1  last byte of the record
- chardata  out  8  byte to SME
- isstring  out  1  string byte strobe to SME
- ispattern  out  1  pattern byte strobe to SME
- sme_valid  in  1  SME result-valid flag
- busy  out  1  state is not FILL
- err_overflow  out  1  one-cycle pulse: the record exceeded its maximum and was truncated
- err_seq  out  1  one-cycle pulse: pattern record arrived with no string loaded; record discarded
- err_timeout  out  1  one-cycle pulse: watchdog expired (SME_WDOG_EN only)

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values:
  - state = FILL; len, rd_ptr and the watchdog counter = 0; str_loaded = 0.
  - in_ready = 1; chardata = 0; isstring = ispattern = 0; busy = 0; all err_* = 0.
  - Buffer contents are don't-care.
- A byte is accepted on a rising edge where in_valid && in_ready.
- States:
  - FILL: in_ready = 1.
    - First byte of a record latches kind = in_is_pattern; later in_is_pattern values are ignored.
    - Each accepted byte is written to buf[len] and len increments, while len < limit (MAX_STR for a string, MAX_PAT for a pattern).
    - Bytes beyond the limit are dropped and a sticky ovf flag is set.
    - When the in_last byte is accepted:
      - if ovf is set, pulse err_overflow on the next cycle;
      - if kind = pattern and str_loaded = 0, pulse err_seq, clear len and stay in FILL;
      - otherwise go to EMIT with rd_ptr = 0.
  - EMIT: in_ready = 0.
    - chardata = buf[rd_ptr] (registered); isstring = !kind; ispattern = kind.
    - Exactly len consecutive cycles, beginning the cycle after in_last is accepted, with no gaps.
    - After the final byte:
      - string record: set str_loaded = 1, clear len, go to FILL;
      - pattern record: clear len, go to WAIT.
  - WAIT: in_ready = 0; strobes low. Go to FILL on the first cycle sme_valid = 1.
- sme_valid is ignored outside WAIT. A level left high from a previous result must not release the next WAIT early: WAIT is entered only after ispattern has been high, and the SME drops valid while ispattern is high.
- A new string record replaces the SME string; str_loaded stays 1.
- A string record following a pattern is legal.
- in_valid with in_ready = 0 is held by upstream and has no effect.
- Record lengths:
  - single-byte record (first byte carries in_last): a 1-cycle burst;
  - record of exactly MAX_STR bytes: no overflow.
- len and rd_ptr are 6 bits wide. rd_ptr never wraps; it stops at len-1.
- Reset mid-EMIT or mid-WAIT: strobes drop asynchronously and state returns to FILL. Any partial burst already sent is not repeated.

Optional Feature:
- Macro SME_WDOG_EN.
- Defined:
  - A counter runs in WAIT.
  - If WDOG_CYCLES cycles elapse without sme_valid, pulse err_timeout for one cycle, go to FILL, and clear str_loaded.
  - The counter clears on entry to WAIT.
- Undefined: WAIT lasts indefinitely; err_timeout is tied to 0.

Test Plan:
- Reset, then string "ab c" (4 bytes, last on 'c') -> isstring high for exactly 4 consecutive cycles carrying 0x61,0x62,0x20,0x63, starting the cycle after 'c' is accepted; then in_ready = 1.
- String "abc", then pattern "^b." -> ispattern for 3 cycles (0x5E,0x62,0x2E), then WAIT with in_ready = 0. sme_valid asserted 5 cycles later -> in_ready = 1 the next cycle.
- Pattern "ab" sent directly after reset -> err_seq pulses once; no ispattern strobe; in_ready stays 1.
- 40-byte string -> isstring for exactly 32 cycles carrying bytes 0..31; err_overflow pulses once.
- Upstream in_valid toggled 1,0,1,0 during a 3-byte string -> output burst is still 3 contiguous isstring cycles.
- With SME_WDOG_EN and WDOG_CYCLES = 8: string, then pattern, sme_valid held 0 -> err_timeout pulses 8 cycles after WAIT entry. A following pattern then gives err_seq.

Source files
------------

// File: rtl/sme_record_feeder.sv
// sme_record_feeder: upstream stage of the string-matching engine.
// Assembles string/pattern records from a valid/ready byte stream into a
// local buffer. Each record is replayed to the SME as one gap-free burst.
// After a pattern burst, input is held off until the SME reports a result.
// Optional feature: define SME_WDOG_EN to bound the wait for sme_valid with
// a WDOG_CYCLES watchdog that pulses err_timeout.
module sme_record_feeder #(
  parameter int MAX_STR     = 32,
  parameter int MAX_PAT     = 10,
  parameter int WDOG_CYCLES = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_pattern,
  input  logic       in_last,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       sme_valid,
  output logic       busy,
  output logic       err_overflow,
  output logic       err_seq,
  output logic       err_timeout
);

  typedef enum logic [1:0] {S_FILL, S_EMIT, S_WAIT} state_t;

  localparam int         AW      = $clog2(MAX_STR);
  localparam logic [5:0] STR_LIM = 6'(MAX_STR);
  localparam logic [5:0] PAT_LIM = 6'(MAX_PAT);

  state_t     state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [5:0] rd_ptr_q, rd_ptr_d;
  logic       kind_q, kind_d;
  logic       ovf_q, ovf_d;
  logic       str_loaded_q, str_loaded_d;
  logic       in_ready_q, in_ready_d;
  logic [7:0] chardata_q, chardata_d;
  logic       isstring_q, isstring_d;
  logic       ispattern_q, ispattern_d;
  logic       busy_q, busy_d;
  logic       err_overflow_q, err_overflow_d;
  logic       err_seq_q, err_seq_d;

  logic [7:0]    mem_q [MAX_STR];
  logic          mem_we;
  logic [AW-1:0] nxt_idx;
  logic          accept;
  logic          cur_kind;
  logic [5:0]    limit;
  logic          has_room;

`ifdef SME_WDOG_EN
  localparam int WW = $clog2(WDOG_CYCLES + 1);
  logic [WW-1:0] wdog_q, wdog_d;
  logic          err_timeout_q, err_timeout_d;
`endif

  // Per-byte decode: record kind comes from the first byte only (len == 0).
  assign accept   = in_valid && in_ready_q;
  assign cur_kind = (len_q == 6'd0) ? in_is_pattern : kind_q;
  assign limit    = cur_kind ? PAT_LIM : STR_LIM;
  assign has_room = (len_q < limit);
  assign nxt_idx  = AW'(rd_ptr_q + 6'd1);

  // Next-state and next-output computation for the FILL/EMIT/WAIT sequencer.
  always_comb begin
    // NOTE: every variable gets a default here so no path leaves one unassigned, which would infer a latch.
    state_d        = state_q;
    len_d          = len_q;
    rd_ptr_d       = rd_ptr_q;
    kind_d         = kind_q;
    ovf_d          = ovf_q;
    str_loaded_d   = str_loaded_q;
    in_ready_d     = in_ready_q;
    chardata_d     = chardata_q;
    isstring_d     = 1'b0;
    ispattern_d    = 1'b0;
    busy_d         = busy_q;
    err_overflow_d = 1'b0;
    err_seq_d      = 1'b0;
    mem_we         = 1'b0;
`ifdef SME_WDOG_EN
    wdog_d         = wdog_q;
    err_timeout_d  = 1'b0;
`endif
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          kind_d = cur_kind;
          if (has_room) begin
            mem_we = 1'b1;
            len_d  = len_q + 6'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            err_overflow_d = ovf_q || !has_room;
            ovf_d          = 1'b0;
            if (cur_kind && !str_loaded_q) begin
              err_seq_d = 1'b1;
              len_d     = 6'd0;
            end else begin
              // First byte goes out on the very next cycle; a one-byte
              // record has not reached the buffer yet, so bypass it.
              state_d     = S_EMIT;
              rd_ptr_d    = 6'd0;
              in_ready_d  = 1'b0;
              busy_d      = 1'b1;
              chardata_d  = (len_q == 6'd0) ? in_data : mem_q[0];
              isstring_d  = !cur_kind;
              ispattern_d = cur_kind;
            end
          end
        end
      end
      S_EMIT: begin
        if (rd_ptr_q == len_q - 6'd1) begin
          len_d = 6'd0;
          if (kind_q) begin
            state_d = S_WAIT;
`ifdef SME_WDOG_EN
            wdog_d  = '0;
`endif
          end else begin
            state_d      = S_FILL;
            str_loaded_d = 1'b1;
            in_ready_d   = 1'b1;
            busy_d       = 1'b0;
          end
        end else begin
          rd_ptr_d    = rd_ptr_q + 6'd1;
          chardata_d  = mem_q[nxt_idx];
          isstring_d  = !kind_q;
          ispattern_d = kind_q;
        end
      end
      S_WAIT: begin
        if (sme_valid) begin
          state_d    = S_FILL;
          in_ready_d = 1'b1;
          busy_d     = 1'b0;
        end
`ifdef SME_WDOG_EN
        else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
          state_d       = S_FILL;
          in_ready_d    = 1'b1;
          busy_d        = 1'b0;
          str_loaded_d  = 1'b0;
          err_timeout_d = 1'b1;
        end else begin
          wdog_d = wdog_q + WW'(1);
        end
`endif
      end
      default: begin
        state_d    = S_FILL;
        in_ready_d = 1'b1;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and registered outputs; asynchronous active-high reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_FILL;
      len_q          <= 6'd0;
      rd_ptr_q       <= 6'd0;
      kind_q         <= 1'b0;
      ovf_q          <= 1'b0;
      str_loaded_q   <= 1'b0;
      in_ready_q     <= 1'b1;
      chardata_q     <= 8'd0;
      isstring_q     <= 1'b0;
      ispattern_q    <= 1'b0;
      busy_q         <= 1'b0;
      err_overflow_q <= 1'b0;
      err_seq_q      <= 1'b0;
`ifdef SME_WDOG_EN
      wdog_q         <= '0;
      err_timeout_q  <= 1'b0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together from pre-edge values.
      state_q        <= state_d;
      len_q          <= len_d;
      rd_ptr_q       <= rd_ptr_d;
      kind_q         <= kind_d;
      ovf_q          <= ovf_d;
      str_loaded_q   <= str_loaded_d;
      in_ready_q     <= in_ready_d;
      chardata_q     <= chardata_d;
      isstring_q     <= isstring_d;
      ispattern_q    <= ispattern_d;
      busy_q         <= busy_d;
      err_overflow_q <= err_overflow_d;
      err_seq_q      <= err_seq_d;
`ifdef SME_WDOG_EN
      wdog_q         <= wdog_d;
      err_timeout_q  <= err_timeout_d;
`endif
    end
  end

  // Record buffer write port.
  always_ff @(posedge clk) begin
    // NOTE: the buffer has no reset; len gates every read, so stale contents are never observed.
    if (mem_we) mem_q[len_q[AW-1:0]] <= in_data;
  end

  assign in_ready     = in_ready_q;
  assign chardata     = chardata_q;
  assign isstring     = isstring_q;
  assign ispattern    = ispattern_q;
  assign busy         = busy_q;
  assign err_overflow = err_overflow_q;
  assign err_seq      = err_seq_q;
`ifdef SME_WDOG_EN
  assign err_timeout  = err_timeout_q;
`else
  assign err_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_sme_record_feeder.sv
// Directed self-checking bench for sme_record_feeder.
// With SME_WDOG_EN defined the watchdog is exercised with WDOG_CYCLES = 8.
module tb_sme_record_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_is_pattern;
  logic       in_last;
  logic [7:0] chardata;
  logic       isstring;
  logic       ispattern;
  logic       sme_valid;
  logic       busy;
  logic       err_overflow;
  logic       err_seq;
  logic       err_timeout;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_bytes[$];

  sme_record_feeder #(.MAX_STR(32), .MAX_PAT(10), .WDOG_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_is_pattern(in_is_pattern),
    .in_last      (in_last),
    .chardata     (chardata),
    .isstring     (isstring),
    .ispattern    (ispattern),
    .sme_valid    (sme_valid),
    .busy         (busy),
    .err_overflow (err_overflow),
    .err_seq      (err_seq),
    .err_timeout  (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for one cycle; caller ensures in_ready is high.
  task automatic send(input logic [7:0] d, input logic last, input logic pat);
    in_valid      = 1'b1;
    in_data       = d;
    in_last       = last;
    in_is_pattern = pat;
    tick();
    in_valid      = 1'b0;
    in_last       = 1'b0;
  endtask

  // Checks a burst of exp_bytes starting in the current cycle.
  task automatic expect_burst(input string tag, input logic pat);
    for (int i = 0; i < exp_bytes.size(); i++) begin
      check({tag, " strobe"}, pat ? ispattern : isstring, 1'b1);
      check({tag, " other"},  pat ? isstring : ispattern, 1'b0);
      check({tag, " data"},   chardata, exp_bytes[i]);
      check({tag, " ready"},  in_ready, 1'b0);
      tick();
    end
    check({tag, " end strobes"}, {isstring, ispattern}, 2'b00);
  endtask

  initial begin
    reset         = 1'b1;
    in_valid      = 1'b0;
    in_data       = 8'h00;
    in_is_pattern = 1'b0;
    in_last       = 1'b0;
    sme_valid     = 1'b0;
    #22 reset = 1'b0;
    tick();

    // Reset state
    check("rst in_ready", in_ready, 1'b1);
    check("rst strobes", {isstring, ispattern}, 2'b00);
    check("rst chardata", chardata, 8'h00);
    check("rst busy", busy, 1'b0);
    check("rst errs", {err_overflow, err_seq, err_timeout}, 3'b000);

    // Pattern with no string loaded: discarded with err_seq
    send("a", 1'b0, 1'b1);
    send("b", 1'b1, 1'b1);
    check("seq err_seq", err_seq, 1'b1);
    check("seq no strobe", {isstring, ispattern}, 2'b00);
    check("seq ready", in_ready, 1'b1);
    tick();
    check("seq pulse end", err_seq, 1'b0);
    check("seq still fill", busy, 1'b0);

    // String "ab c"
    send("a", 1'b0, 1'b0);
    send("b", 1'b0, 1'b0);
    send(" ", 1'b0, 1'b0);
    send("c", 1'b1, 1'b0);
    check("abc busy", busy, 1'b1);
    exp_bytes = '{8'h61, 8'h62, 8'h20, 8'h63};
    expect_burst("str4", 1'b0);
    check("str4 ready after", in_ready, 1'b1);
    check("str4 idle", busy, 1'b0);

    // String "abc" then pattern "^b." then WAIT released by sme_valid
    send("a", 1'b0, 1'b0);
    send("b", 1'b0, 1'b0);
    send("c", 1'b1, 1'b0);
    exp_bytes = '{8'h61, 8'h62, 8'h63};
    expect_burst("str3", 1'b0);
    send("^", 1'b0, 1'b1);
    send("b", 1'b0, 1'b1);
    send(".", 1'b1, 1'b1);
    exp_bytes = '{8'h5E, 8'h62, 8'h2E};
    expect_burst("pat3", 1'b1);
    check("wait ready", in_ready, 1'b0);
    check("wait busy", busy, 1'b1);
    repeat (4) tick();
    check("wait hold ready", in_ready, 1'b0);
    check("wait no err", err_timeout, 1'b0);
    sme_valid = 1'b1;
    tick();
    sme_valid = 1'b0;
    check("release ready", in_ready, 1'b1);
    check("release busy", busy, 1'b0);

    // 40-byte string: truncated to 32 with err_overflow
    for (int i = 0; i < 40; i++) send(8'(i), (i == 39), 1'b0);
    check("ovf pulse", err_overflow, 1'b1);
    exp_bytes.delete();
    for (int i = 0; i < 32; i++) exp_bytes.push_back(8'(i));
    expect_burst("ovf40", 1'b0);
    check("ovf pulse once", err_overflow, 1'b0);

    // Exactly 32 bytes: no overflow
    for (int i = 0; i < 32; i++) send(8'(8'h80 + i), (i == 31), 1'b0);
    check("full32 no ovf", err_overflow, 1'b0);
    exp_bytes.delete();
    for (int i = 0; i < 32; i++) exp_bytes.push_back(8'(8'h80 + i));
    expect_burst("full32", 1'b0);

    // Single-byte record
    send("z", 1'b1, 1'b0);
    exp_bytes = '{8'h7A};
    expect_burst("one", 1'b0);
    check("one ready", in_ready, 1'b1);

    // Gappy upstream; later in_is_pattern values must be ignored
    send("x", 1'b0, 1'b0);
    tick();
    send("y", 1'b0, 1'b1);
    tick();
    send("w", 1'b1, 1'b1);
    exp_bytes = '{8'h78, 8'h79, 8'h77};
    expect_burst("gap", 1'b0);

    // Reset mid-EMIT: strobes drop at once, nothing is repeated
    send("p", 1'b0, 1'b0);
    send("q", 1'b0, 1'b0);
    send("r", 1'b1, 1'b0);
    check("mid first", chardata, 8'h70);
    tick();
    check("mid second", chardata, 8'h71);
    #2 reset = 1'b1;
    #1;
    check("mid rst strobe", isstring, 1'b0);
    check("mid rst ready", in_ready, 1'b1);
    #2 reset = 1'b0;
    tick();
    check("mid no repeat", {isstring, ispattern}, 2'b00);
    // str_loaded was cleared by reset
    send("^", 1'b1, 1'b1);
    check("mid seq", err_seq, 1'b1);
    check("mid seq no strobe", ispattern, 1'b0);
    tick();

`ifdef SME_WDOG_EN
    // Watchdog: WAIT with no sme_valid times out after 8 cycles
    send("k", 1'b1, 1'b0);
    exp_bytes = '{8'h6B};
    expect_burst("wd str", 1'b0);
    send("^", 1'b0, 1'b1);
    send("k", 1'b1, 1'b1);
    exp_bytes = '{8'h5E, 8'h6B};
    expect_burst("wd pat", 1'b1);
    for (int i = 1; i < 8; i++) begin
      check("wd quiet", err_timeout, 1'b0);
      tick();
    end
    check("wd quiet last", err_timeout, 1'b0);
    tick();
    check("wd timeout", err_timeout, 1'b1);
    check("wd ready", in_ready, 1'b1);
    tick();
    check("wd pulse once", err_timeout, 1'b0);
    send("^", 1'b1, 1'b1);
    check("wd then seq", err_seq, 1'b1);
    tick();
`else
    // Without the watchdog, WAIT persists until sme_valid
    send("k", 1'b1, 1'b0);
    exp_bytes = '{8'h6B};
    expect_burst("nw str", 1'b0);
    send("^", 1'b1, 1'b1);
    exp_bytes = '{8'h5E};
    expect_burst("nw pat", 1'b1);
    repeat (20) tick();
    check("nw still wait", in_ready, 1'b0);
    check("nw no timeout", err_timeout, 1'b0);
    sme_valid = 1'b1;
    tick();
    sme_valid = 1'b0;
    check("nw release", in_ready, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
